// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The default pattern is the one the 0110011 Moore detector recognises.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      GAP    = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int                     DEF_PAT_LEN = 7;
   localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 7'b0110011;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first on o_w, i_count times,
// with i_gap idle cycles between repetitions. All outputs are registered.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int                 PAT_LEN    = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN    = DEF_PATTERN,
   parameter logic               IDLE_LEVEL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [3:0] i_count,
   input  logic [3:0] i_gap,
   input  logic       i_abort,
   output logic       o_w,
   output logic       o_frame,
   output logic       o_busy,
   output logic       o_done,
   output logic [3:0] o_reps_sent,
   output state_t     o_state
);

   localparam int                 IDX_W    = $clog2(PAT_LEN);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PAT_LEN - 1);

   // Handshake: i_start is honoured only in IDLE with a non-zero i_count;
   // o_busy then stays high until the cycle after the one-cycle o_done pulse,
   // or drops the cycle after i_abort is seen in SEND/GAP (no o_done then).
   state_t           r_state;
   logic [IDX_W-1:0] r_bit_idx;
   logic [3:0]       r_gap_cnt;
   logic [3:0]       r_count;
   logic [3:0]       r_gap;
   logic [3:0]       r_reps;
   logic             r_w;
   logic             r_frame;
   logic             r_busy;
   logic             r_done;

   logic [IDX_W-1:0] w_idx_dec;
   logic [3:0]       w_reps_inc;
   logic             w_last_rep;

   assign w_idx_dec  = r_bit_idx - IDX_W'(1);
   assign w_reps_inc = r_reps + 4'd1;
   assign w_last_rep = (w_reps_inc == r_count);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_bit_idx <= '0;
         r_gap_cnt <= '0;
         r_count   <= '0;
         r_gap     <= '0;
         r_reps    <= '0;
         r_w       <= IDLE_LEVEL;
         r_frame   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start && (i_count != 4'd0)) begin
                  r_count   <= i_count;
                  r_gap     <= i_gap;
                  r_reps    <= '0;
                  r_bit_idx <= LAST_IDX;
                  r_w       <= PATTERN[LAST_IDX];
                  r_frame   <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= SEND;
               end
            end

            SEND: begin
               if (i_abort) begin
                  // Abort wins over the end-of-repetition decision below.
                  r_w     <= IDLE_LEVEL;
                  r_frame <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_bit_idx == '0) begin
                  r_reps <= w_reps_inc;
                  if (w_last_rep) begin
                     r_w     <= IDLE_LEVEL;
                     r_frame <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= FINISH;
                  end else if (r_gap == 4'd0) begin
                     r_bit_idx <= LAST_IDX;
                     r_w       <= PATTERN[LAST_IDX];
                  end else begin
                     r_gap_cnt <= r_gap;
                     r_w       <= IDLE_LEVEL;
                     r_frame   <= 1'b0;
                     r_state   <= GAP;
                  end
               end else begin
                  r_bit_idx <= w_idx_dec;
                  r_w       <= PATTERN[w_idx_dec];
               end
            end

            GAP: begin
               r_gap_cnt <= r_gap_cnt - 4'd1;
               if (i_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_gap_cnt == 4'd1) begin
                  r_bit_idx <= LAST_IDX;
                  r_w       <= PATTERN[LAST_IDX];
                  r_frame   <= 1'b1;
                  r_state   <= SEND;
               end
            end

            FINISH: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_w     <= IDLE_LEVEL;
               r_frame <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_w         = r_w;
   assign o_frame     = r_frame;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_reps_sent = r_reps;
   assign o_state     = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle scoreboard, table of transfers, and a
// behavioural 0110011 detector on the loopback line.
module tb_seq_pattern_tx;
   import seq_pkg::*;

   localparam logic [6:0] PAT = 7'b0110011;

   logic       clk;
   logic       reset;
   logic       i_start;
   logic [3:0] i_count;
   logic [3:0] i_gap;
   logic       i_abort;
   logic       o_w;
   logic       o_frame;
   logic       o_busy;
   logic       o_done;
   logic [3:0] o_reps_sent;
   state_t     o_state;

   seq_pattern_tx dut (
      .clk         (clk),
      .reset       (reset),
      .i_start     (i_start),
      .i_count     (i_count),
      .i_gap       (i_gap),
      .i_abort     (i_abort),
      .o_w         (o_w),
      .o_frame     (o_frame),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_reps_sent (o_reps_sent),
      .o_state     (o_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- loopback detector model ----------------
   // Moore detector that returns to its initial state after a match, so the
   // bit following a match is never used.
   logic [6:0] det_hist;
   int         det_len;
   bit         det_skip;
   time        det_t[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         det_hist <= '0;
         det_len  <= 0;
         det_skip <= 1'b0;
      end else if (det_skip) begin
         det_skip <= 1'b0;
      end else begin
         det_hist <= {det_hist[5:0], o_w};
         if (det_len >= 6 && {det_hist[5:0], o_w} == PAT) begin
            det_len  <= 0;
            det_skip <= 1'b1;
            det_t.push_back($time);
         end else if (det_len < 7) begin
            det_len <= det_len + 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [3:0] cnt;
      logic [3:0] gap;
      int         abort_cyc;
      bit         disturb;
      logic [3:0] exp_reps;
      int         exp_done_cyc;
      int         exp_z;
      int         z_space;
   } vec_t;

   logic [9:0] exp_q[$];
   logic [3:0] last_reps;
   int         total;
   int         bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] ev(input state_t st, input logic b, input logic f,
                                     input logic w, input logic d, input logic [3:0] r);
      return {st, b, f, w, d, r};
   endfunction

   task automatic build_expected(input vec_t v);
      int         cyc;
      int         cnt;
      int         gp;
      logic [3:0] reps;
      bit         ab;
      cyc  = 1;
      cnt  = int'(v.cnt);
      gp   = int'(v.gap);
      reps = last_reps;
      ab   = 1'b0;
      if (cnt == 0) begin
         repeat (4) exp_q.push_back(ev(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, reps));
      end else begin
         reps = 4'd0;
         for (int r = 0; r < cnt; r++) begin
            for (int b = 0; b < 7; b++) begin
               if (!ab) begin
                  exp_q.push_back(ev(SEND, 1'b1, 1'b1, PAT[6-b], 1'b0, reps));
                  if (cyc == v.abort_cyc) ab = 1'b1;
                  cyc++;
               end
            end
            if (!ab) reps = reps + 4'd1;
            if (r < cnt - 1) begin
               for (int g = 0; g < gp; g++) begin
                  if (!ab) begin
                     exp_q.push_back(ev(GAP, 1'b1, 1'b0, 1'b1, 1'b0, reps));
                     if (cyc == v.abort_cyc) ab = 1'b1;
                     cyc++;
                  end
               end
            end
         end
         if (!ab) exp_q.push_back(ev(FINISH, 1'b1, 1'b0, 1'b1, 1'b1, reps));
         exp_q.push_back(ev(IDLE, 1'b0, 1'b0, 1'b1, 1'b0, reps));
      end
      last_reps = reps;
   endtask

   // ---------------- driver ----------------
   // Entered at a negedge with the DUT in IDLE; that cycle is cycle 0.
   task automatic run_vec(input int id, input vec_t v);
      int         n;
      int         base;
      int         done_cyc;
      logic [9:0] exp;
      logic [9:0] act;
      build_expected(v);
      base     = det_t.size();
      done_cyc = 0;
      i_count  = v.cnt;
      i_gap    = v.gap;
      i_start  = 1'b1;
      i_abort  = 1'b0;
      n        = exp_q.size();
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         act = {o_state, o_busy, o_frame, o_w, o_done, o_reps_sent};
         check($sformatf("v%0d cyc%0d {st,busy,frame,w,done,reps}", id, c), 32'(act), 32'(exp));
         if (o_done && done_cyc == 0) done_cyc = c;
         i_start = (v.cnt == 4'd0) || (v.disturb && c >= 3 && c <= 5);
         if (v.disturb && c >= 3) begin
            i_count = 4'd9;
            i_gap   = 4'd5;
         end
         i_abort = (c == v.abort_cyc);
      end
      i_start = 1'b0;
      i_abort = 1'b0;
      check($sformatf("v%0d reps_sent", id), 32'(o_reps_sent), 32'(v.exp_reps));
      check($sformatf("v%0d done cycle", id), done_cyc, v.exp_done_cyc);
      check($sformatf("v%0d detector matches", id), det_t.size() - base, v.exp_z);
      if (v.z_space != 0 && det_t.size() >= base + v.exp_z) begin
         for (int k = 1; k < v.exp_z; k++)
            check($sformatf("v%0d match spacing %0d", id, k),
                  32'(det_t[base+k] - det_t[base+k-1]), 32'(v.z_space * 10));
      end
   endtask

   // ---------------- test ----------------
   vec_t vecs[9];
   vec_t rv;

   initial begin
      total     = 0;
      bad       = 0;
      last_reps = 4'd0;
      //           cnt    gap    abort dist reps  done z  space
      vecs[0] = '{4'd1,  4'd0,  0,  1'b0, 4'd1,  8,   1, 0};
      vecs[1] = '{4'd3,  4'd2,  0,  1'b0, 4'd3,  26,  3, 9};
      vecs[2] = '{4'd0,  4'd3,  0,  1'b0, 4'd3,  0,   0, 0};
      vecs[3] = '{4'd4,  4'd1,  11, 1'b0, 4'd1,  0,   1, 0};
      vecs[4] = '{4'd2,  4'd0,  0,  1'b1, 4'd2,  15,  1, 0};
      vecs[5] = '{4'd2,  4'd3,  9,  1'b0, 4'd1,  0,   1, 0};
      vecs[6] = '{4'd1,  4'd0,  7,  1'b0, 4'd0,  0,   1, 0};
      vecs[7] = '{4'd15, 4'd0,  0,  1'b0, 4'd15, 106, 8, 14};
      vecs[8] = '{4'd2,  4'd15, 0,  1'b0, 4'd2,  30,  2, 22};

      reset   = 1'b0;
      i_start = 1'b0;
      i_count = 4'd0;
      i_gap   = 4'd0;
      i_abort = 1'b0;
      repeat (3) @(negedge clk);
      check("reset w", 32'(o_w), 32'd1);
      check("reset frame", 32'(o_frame), 32'd0);
      check("reset busy", 32'(o_busy), 32'd0);
      check("reset done", 32'(o_done), 32'd0);
      check("reset reps", 32'(o_reps_sent), 32'd0);
      check("reset state", 32'(o_state), 32'(IDLE));
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Reset mid-SEND, while a 0 bit is on the line and one rep is done.
      i_count = 4'd3;
      i_gap   = 4'd1;
      i_start = 1'b1;
      repeat (9) begin
         @(negedge clk);
         i_start = 1'b0;
      end
      check("pre-reset w", 32'(o_w), 32'd0);
      check("pre-reset reps", 32'(o_reps_sent), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("async reset w", 32'(o_w), 32'd1);
      check("async reset busy", 32'(o_busy), 32'd0);
      check("async reset frame", 32'(o_frame), 32'd0);
      check("async reset reps", 32'(o_reps_sent), 32'd0);
      check("async reset state", 32'(o_state), 32'(IDLE));
      @(negedge clk);
      reset     = 1'b1;
      last_reps = 4'd0;
      @(negedge clk);
      run_vec(9, vecs[0]);

      for (int i = 0; i < 3; i++) begin
         rv.cnt          = 4'($urandom_range(1, 5));
         rv.gap          = 4'($urandom_range(0, 4));
         rv.abort_cyc    = 0;
         rv.disturb      = 1'b0;
         rv.exp_reps     = rv.cnt;
         rv.exp_done_cyc = int'(rv.cnt) * 7 + (int'(rv.cnt) - 1) * int'(rv.gap) + 1;
         rv.exp_z        = (rv.gap != 4'd0) ? int'(rv.cnt) : (int'(rv.cnt) + 1) / 2;
         rv.z_space      = (rv.gap != 4'd0) ? 7 + int'(rv.gap) : 14;
         run_vec(10 + i, rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
